// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 opcodes, T-state one-hot constants and control-word bit indices
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef logic [5:0] tstate_t;

    localparam tstate_t T1 = 6'b000001;
    localparam tstate_t T2 = 6'b000010;
    localparam tstate_t T3 = 6'b000100;
    localparam tstate_t T4 = 6'b001000;
    localparam tstate_t T5 = 6'b010000;
    localparam tstate_t T6 = 6'b100000;

    localparam int CW_PC_OUT   = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_PC_LOAD  = 2;
    localparam int CW_MAR_LOAD = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_IR_LOAD  = 5;
    localparam int CW_IR_OUT   = 6;
    localparam int CW_A_LOAD   = 7;
    localparam int CW_A_OUT    = 8;
    localparam int CW_B_LOAD   = 9;
    localparam int CW_OUT_LOAD = 10;
    localparam int CW_EU       = 11;
    localparam int CW_ADD      = 12;
    localparam int CW_SUB      = 13;
    localparam int CW_AND      = 14;
    localparam int CW_OR       = 15;
    localparam int CW_XOR      = 16;
    localparam int CW_NOT      = 17;
    localparam int CW_W        = 18;

endpackage

// File: rtl/sap1_ring_counter.sv
// rtl/sap1_ring_counter.sv - six-phase one-hot T-state ring, T6 wraps to T1
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    advance,
    output tstate_t t_state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state <= T1;
        end else if (advance) begin
            t_state <= {t_state[4:0], t_state[5]};
        end
    end

endmodule

// File: rtl/sap1_control_unit.sv
// rtl/sap1_control_unit.sv - SAP-1 sequencer and opcode decode; optional JMP via SAP1_JMP_EN
module sap1_control_unit
    import sap1_pkg::*;
#(
    parameter int OPCODE_W        = 4,
    parameter bit HALT_ON_UNKNOWN = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                out_load,
    output logic                eu,
    output logic                add,
    output logic                sub,
    output logic                and_op,
    output logic                or_op,
    output logic                xor_op,
    output logic                not_op,
    output logic [5:0]          t_state,
    output logic                halted
);

    logic            advance;
    logic            op_known;
    logic            halt_req;
    logic [CW_W-1:0] cw;
    logic [CW_W-1:0] cw_g;

    assign advance = run & ~halted;

    sap1_ring_counter u_ring (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .t_state (t_state)
    );

    always_comb begin
        op_known = 1'b1;
        case (opcode)
            OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB),
            OPCODE_W'(OP_AND), OPCODE_W'(OP_OR),  OPCODE_W'(OP_XOR),
            OPCODE_W'(OP_NOT), OPCODE_W'(OP_OUT), OPCODE_W'(OP_HLT): op_known = 1'b1;
`ifdef SAP1_JMP_EN
            OPCODE_W'(OP_JMP): op_known = 1'b1;
`endif
            default: op_known = 1'b0;
        endcase
    end

    assign halt_req = (t_state == T4) &&
                      ((opcode == OPCODE_W'(OP_HLT)) || (HALT_ON_UNKNOWN && !op_known));

    // halted is sticky; only the T4 edge of a halting opcode sets it, and only when advancing
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (advance && halt_req) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        cw = '0;
        case (t_state)
            T1: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            T2: cw[CW_PC_INC] = 1'b1;
            T3: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
            end
            T4: begin
                case (opcode)
                    OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB),
                    OPCODE_W'(OP_AND), OPCODE_W'(OP_OR),  OPCODE_W'(OP_XOR): begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OPCODE_W'(OP_NOT): begin
                        cw[CW_EU]     = 1'b1;
                        cw[CW_NOT]    = 1'b1;
                        cw[CW_A_LOAD] = 1'b1;
                    end
                    OPCODE_W'(OP_OUT): begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
`ifdef SAP1_JMP_EN
                    OPCODE_W'(OP_JMP): begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OPCODE_W'(OP_LDA): begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end
                    OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB), OPCODE_W'(OP_AND),
                    OPCODE_W'(OP_OR),  OPCODE_W'(OP_XOR): begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (opcode)
                    OPCODE_W'(OP_ADD): cw[CW_ADD] = 1'b1;
                    OPCODE_W'(OP_SUB): cw[CW_SUB] = 1'b1;
                    OPCODE_W'(OP_AND): cw[CW_AND] = 1'b1;
                    OPCODE_W'(OP_OR):  cw[CW_OR]  = 1'b1;
                    OPCODE_W'(OP_XOR): cw[CW_XOR] = 1'b1;
                    default: ;
                endcase
                if (cw[CW_ADD] | cw[CW_SUB] | cw[CW_AND] | cw[CW_OR] | cw[CW_XOR]) begin
                    cw[CW_EU]     = 1'b1;
                    cw[CW_A_LOAD] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cw_g = (run & ~halted & ~rst) ? cw : '0;

    assign pc_out   = cw_g[CW_PC_OUT];
    assign pc_inc   = cw_g[CW_PC_INC];
    assign pc_load  = cw_g[CW_PC_LOAD];
    assign mar_load = cw_g[CW_MAR_LOAD];
    assign ram_out  = cw_g[CW_RAM_OUT];
    assign ir_load  = cw_g[CW_IR_LOAD];
    assign ir_out   = cw_g[CW_IR_OUT];
    assign a_load   = cw_g[CW_A_LOAD];
    assign a_out    = cw_g[CW_A_OUT];
    assign b_load   = cw_g[CW_B_LOAD];
    assign out_load = cw_g[CW_OUT_LOAD];
    assign eu       = cw_g[CW_EU];
    assign add      = cw_g[CW_ADD];
    assign sub      = cw_g[CW_SUB];
    assign and_op   = cw_g[CW_AND];
    assign or_op    = cw_g[CW_OR];
    assign xor_op   = cw_g[CW_XOR];
    assign not_op   = cw_g[CW_NOT];

endmodule

// File: tb/tb_sap1_control_unit.sv
// tb/tb_sap1_control_unit.sv - table, sequence and random checks of sap1_control_unit
module tb_sap1_control_unit;

    localparam bit HOU = 1'b0;

    logic       clk;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out, a_load, a_out;
    logic b_load, out_load, eu, add, sub, and_op, or_op, xor_op, not_op;
    logic [5:0] t_state;
    logic       halted;

    sap1_control_unit #(.OPCODE_W(4), .HALT_ON_UNKNOWN(HOU)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
        .ram_out(ram_out), .ir_load(ir_load), .ir_out(ir_out), .a_load(a_load),
        .a_out(a_out), .b_load(b_load), .out_load(out_load), .eu(eu), .add(add),
        .sub(sub), .and_op(and_op), .or_op(or_op), .xor_op(xor_op), .not_op(not_op),
        .t_state(t_state), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bench control-word layout: bit 17 = pc_out ... bit 0 = not_op
    localparam logic [17:0] PO = 18'h20000, PI = 18'h10000, PL = 18'h08000, ML = 18'h04000;
    localparam logic [17:0] RO = 18'h02000, IL = 18'h01000, IO = 18'h00800, AL = 18'h00400;
    localparam logic [17:0] AO = 18'h00200, BL = 18'h00100, OL = 18'h00080, EU = 18'h00040;
    localparam logic [17:0] ADD = 18'h00020, NOT = 18'h00001;

    int checks = 0;
    int passed = 0;
    int m_phase = 1;
    bit m_halted = 1'b0;
    bit pc_load_seen = 1'b0;

    function automatic logic [17:0] got_cw();
        return {pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out, a_load, a_out,
                b_load, out_load, eu, add, sub, and_op, or_op, xor_op, not_op};
    endfunction

    function automatic bit is_alu(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit is_jmp(input logic [3:0] op);
`ifdef SAP1_JMP_EN
        return op == 4'd7;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_known(input logic [3:0] op);
        return (op <= 4'd6) || (op >= 4'd14) || is_jmp(op);
    endfunction

    function automatic logic [17:0] model_cw(input int ph, input logic [3:0] op,
                                             input bit r, input bit rn, input bit h);
        logic [17:0] w;
        w = '0;
        if (r || !rn || h) return w;
        case (ph)
            1: w = PO | ML;
            2: w = PI;
            3: w = RO | IL;
            4: begin
                if (op == 4'd0 || is_alu(op)) w = IO | ML;
                else if (op == 4'd6) w = EU | NOT | AL;
                else if (op == 4'd14) w = AO | OL;
                else if (is_jmp(op)) w = IO | PL;
            end
            5: begin
                if (op == 4'd0) w = RO | AL;
                else if (is_alu(op)) w = RO | BL;
            end
            default: if (is_alu(op)) w = EU | AL | (18'd1 << (6 - int'(op)));
        endcase
        return w;
    endfunction

    task automatic report(input string name, input bit ok, input logic [31:0] got,
                          input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic check_rules();
        int drivers;
        int ops;
        drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(eu);
        ops = int'(add) + int'(sub) + int'(and_op) + int'(or_op) + int'(xor_op) + int'(not_op);
        if (pc_load) pc_load_seen = 1'b1;
        report("bus_rule", drivers <= 1, 32'(drivers), 32'd1);
        report("eu_onehot", ops == (eu ? 1 : 0), 32'(ops), {31'd0, eu});
    endtask

    task automatic check_model(input string name);
        logic [24:0] exp;
        logic [24:0] got;
        exp = {6'(1) << (m_phase - 1), m_halted, model_cw(m_phase, opcode, rst, run, m_halted)};
        got = {t_state, halted, got_cw()};
        report(name, got === exp, 32'(got), 32'(exp));
        check_rules();
    endtask

    task automatic drive(input bit r, input bit rn, input logic [3:0] op);
        rst = r;
        run = rn;
        opcode = op;
        #1;
    endtask

    task automatic clock();
        @(posedge clk);
        if (rst) begin
            m_phase = 1;
            m_halted = 1'b0;
        end else if (run && !m_halted) begin
            if (m_phase == 4 && (opcode == 4'd15 || (HOU && !is_known(opcode)))) m_halted = 1'b1;
            m_phase = (m_phase % 6) + 1;
        end
        @(negedge clk);
    endtask

    task automatic step(input bit r, input bit rn, input logic [3:0] op, input string name);
        drive(r, rn, op);
        check_model(name);
        clock();
    endtask

    typedef struct {
        bit          r;
        bit          rn;
        logic [3:0]  op;
        logic [5:0]  t;
        bit          h;
        logic [17:0] cw;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1, 1, 4'd1, 6'b000001, 0, 18'h0};
        vecs[1] = '{1, 1, 4'd1, 6'b000001, 0, 18'h0};
        vecs[2] = '{0, 1, 4'd1, 6'b000001, 0, PO | ML};
        vecs[3] = '{0, 1, 4'd1, 6'b000010, 0, PI};
        vecs[4] = '{0, 1, 4'd1, 6'b000100, 0, RO | IL};
        vecs[5] = '{0, 1, 4'd1, 6'b001000, 0, IO | ML};
        vecs[6] = '{0, 1, 4'd1, 6'b010000, 0, RO | BL};
        vecs[7] = '{0, 1, 4'd1, 6'b100000, 0, EU | ADD | AL};
        vecs[8] = '{0, 1, 4'd1, 6'b000001, 0, PO | ML};

        rst = 1'b1; run = 1'b0; opcode = 4'd0;
        @(posedge clk);
        @(negedge clk);

        // reset and one ADD instruction from constant vectors
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].r, vecs[i].rn, vecs[i].op);
            report($sformatf("vec%0d", i), {t_state, halted, got_cw()} === {vecs[i].t, vecs[i].h, vecs[i].cw},
                   32'({t_state, halted, got_cw()}), 32'({vecs[i].t, vecs[i].h, vecs[i].cw}));
            check_rules();
            clock();
        end

        // sweep every opcode through a full instruction
        for (int op = 0; op < 16; op++) begin
            step(1, 1, 4'(op), "sweep_rst");
            for (int c = 0; c < 6; c++) step(0, 1, 4'(op), $sformatf("sweep_op%0d_c%0d", op, c));
        end

        // HLT: sticky, frozen at T5
        step(1, 1, 4'd15, "hlt_rst");
        for (int c = 0; c < 4; c++) step(0, 1, 4'd15, "hlt_fetch");
        for (int c = 0; c < 20; c++) begin
            drive(0, c[0], 4'(c));
            report("hlt_frozen", {t_state, halted, got_cw()} === {6'b010000, 1'b1, 18'h0},
                   32'({t_state, halted, got_cw()}), 32'({6'b010000, 1'b1, 18'h0}));
            clock();
        end
        step(1, 1, 4'd0, "hlt_release");
        drive(0, 1, 4'd0);
        report("hlt_cleared", {t_state, halted} === {6'b000001, 1'b0}, 32'({t_state, halted}), 32'h2);
        clock();

        // run low during T5 holds the phase
        step(1, 1, 4'd1, "pause_rst");
        for (int c = 0; c < 4; c++) step(0, 1, 4'd1, "pause_fetch");
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 4'd1);
            report("pause_hold", {t_state, got_cw()} === {6'b010000, 18'h0},
                   32'({t_state, got_cw()}), 32'({6'b010000, 18'h0}));
            clock();
        end
        drive(0, 1, 4'd1);
        report("pause_resume", got_cw() === (RO | BL), 32'(got_cw()), 32'(RO | BL));
        clock();
        drive(0, 1, 4'd1);
        report("pause_t6", t_state === 6'b100000, 32'(t_state), 32'h20);
        clock();

        // reset at T5 discards the instruction
        step(1, 1, 4'd0, "abort_rst");
        for (int c = 0; c < 4; c++) step(0, 1, 4'd0, "abort_fetch");
        drive(1, 1, 4'd0);
        report("abort_noload", {a_load, b_load} === 2'b00, 32'({a_load, b_load}), 32'h0);
        clock();
        drive(0, 1, 4'd0);
        report("abort_t1", t_state === 6'b000001, 32'(t_state), 32'h1);
        clock();
        m_phase = 2;

        // random stimulus against the reference model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 15)), "random");
        end

`ifdef SAP1_JMP_EN
        report("pc_load_seen", pc_load_seen == 1'b1, 32'(pc_load_seen), 32'h1);
`else
        report("pc_load_never", pc_load_seen == 1'b0, 32'(pc_load_seen), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
